// File: rtl/crypto_cmd_sequencer.sv
// Command sequencer between a 32-bit instruction stream and a block-cipher core.
// Parses header/payload words, assembles key and data-block registers, launches
// the core, supervises it with a watchdog and streams the result back.
//
// Handshakes: a word moves on any rising clock edge where valid and ready are
// both high. instr_ready and out_valid depend only on registered state, so
// neither instr_valid nor out_ready has a combinational path to an output.
module crypto_cmd_sequencer #(
    parameter int KEY_WORDS   = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      instr_valid,
    input  logic [31:0]               instr_data,
    output logic                      instr_ready,
    output logic [32*KEY_WORDS-1:0]   core_key,
    output logic [32*BLOCK_WORDS-1:0] core_block,
    output logic                      core_mode,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [32*BLOCK_WORDS-1:0] core_result,
    output logic                      out_valid,
    output logic [31:0]               out_data,
    input  logic                      out_ready,
    output logic                      err,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_SEND = 2'd3
    } state_t;

    localparam int MAXW = (KEY_WORDS > BLOCK_WORDS) ? KEY_WORDS : BLOCK_WORDS;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt;        // payload word index inside LOAD
    logic                        load_key;   // LOAD target: 1 = key, 0 = block
    logic [CW-1:0]               idx;        // result word index inside SEND
    logic [WW-1:0]               wdog;       // cycles spent in RUN
    logic [32*BLOCK_WORDS-1:0]   result;

    logic instr_fire, out_fire;
    logic hdr_load_key, hdr_load_block, hdr_start, hdr_read, hdr_clear, hdr_bad;
    logic load_wr, load_last, run_done, run_timeout, send_last;

    assign instr_ready = (state == S_IDLE) || (state == S_LOAD);
    assign instr_fire  = instr_valid && instr_ready;
    assign out_fire    = out_valid && out_ready;
    assign dbg_state   = state;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and single-cycle control strobes for the datapath
    always_comb begin
        state_nxt      = state;
        hdr_load_key   = 1'b0;
        hdr_load_block = 1'b0;
        hdr_start      = 1'b0;
        hdr_read       = 1'b0;
        hdr_clear      = 1'b0;
        hdr_bad        = 1'b0;
        load_wr        = 1'b0;
        load_last      = 1'b0;
        run_done       = 1'b0;
        run_timeout    = 1'b0;
        send_last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_fire) begin
                    if (!instr_data[31]) begin
                        hdr_bad = 1'b1;
                    end else begin
                        case (instr_data[3:0])
                            4'd0:    begin hdr_load_key   = 1'b1; state_nxt = S_LOAD; end
                            4'd1:    begin hdr_load_block = 1'b1; state_nxt = S_LOAD; end
                            4'd2:    begin hdr_start      = 1'b1; state_nxt = S_RUN;  end
                            4'd3:    begin hdr_read       = 1'b1; state_nxt = S_SEND; end
                            4'd15:   hdr_clear = 1'b1;
                            default: hdr_bad   = 1'b1;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                if (instr_fire) begin
                    load_wr   = 1'b1;
                    load_last = load_key ? (32'(cnt) == KEY_WORDS - 1)
                                         : (32'(cnt) == BLOCK_WORDS - 1);
                    if (load_last) state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // core_done in the expiry cycle takes priority over the timeout
                if (core_done) begin
                    run_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (TIMEOUT != 0 && 32'(wdog) == TIMEOUT - 1) begin
                    run_timeout = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_SEND: begin
                if (out_fire && 32'(idx) == BLOCK_WORDS - 1) begin
                    send_last = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Key/block assembly and LOAD word counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_key   <= '0;
            core_block <= '0;
            cnt        <= '0;
            load_key   <= 1'b0;
        end else if (hdr_load_key || hdr_load_block) begin
            cnt      <= '0;
            load_key <= hdr_load_key;
        end else if (load_wr) begin
            // First payload word lands in the most significant 32 bits
            if (load_key) core_key[32*(KEY_WORDS-1-32'(cnt)) +: 32]     <= instr_data;
            else          core_block[32*(BLOCK_WORDS-1-32'(cnt)) +: 32] <= instr_data;
            cnt <= load_last ? '0 : cnt + 1'b1;
        end
    end

    // Core launch, watchdog counter and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            wdog       <= '0;
            result     <= '0;
        end else begin
            core_start <= hdr_start;
            if (hdr_start) begin
                core_mode <= instr_data[4];
                wdog      <= '0;
            end else if (state == S_RUN) begin
                wdog <= (run_done || run_timeout) ? '0 : wdog + 1'b1;
            end
            if (run_done) result <= core_result;
        end
    end

    // Sticky error flag: set by stray words, bad opcodes and timeouts; CLEAR resets it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                    err <= 1'b0;
        else if (hdr_bad || run_timeout) err <= 1'b1;
        else if (hdr_clear)              err <= 1'b0;
    end

    // Result streaming, most significant word first; out_data holds while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
        end else if (hdr_read) begin
            out_valid <= 1'b1;
            out_data  <= result[32*(BLOCK_WORDS-1) +: 32];
            idx       <= '0;
        end else if (state == S_SEND && out_fire) begin
            if (send_last) begin
                out_valid <= 1'b0;
                idx       <= '0;
            end else begin
                out_data <= result[32*(BLOCK_WORDS-2-32'(idx)) +: 32];
                idx      <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crypto_cmd_sequencer.sv
// Testbench for crypto_cmd_sequencer: directed scenarios followed by random
// commands, checked against a word-array reference model and a result-word
// scoreboard drained by an independent output monitor.
module tb_crypto_cmd_sequencer;

    localparam int TMO = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic [31:0]  instr_data = '0;
    logic         instr_ready;
    logic [127:0] core_key, core_block;
    logic         core_mode, core_start;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready = 1'b0;
    logic         err;
    logic [1:0]   dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [31:0] m_key[4], m_blk[4], m_res[4];
    logic        m_err, m_mode;
    logic [31:0] exp_q[$];

    crypto_cmd_sequencer #(.KEY_WORDS(4), .BLOCK_WORDS(4), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
        .core_key(core_key), .core_block(core_block), .core_mode(core_mode),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .err(err), .dbg_state(dbg_state)
    );

    // clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] cat4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_key[j] = '0; m_blk[j] = '0; m_res[j] = '0;
        end
        m_err  = 1'b0;
        m_mode = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " key"},        core_key,    '0);
        check({tag, " block"},      core_block,  '0);
        check({tag, " err"},        err,         '0);
        check({tag, " mode"},       core_mode,   '0);
        check({tag, " start"},      core_start,  '0);
        check({tag, " out_valid"},  out_valid,   '0);
        check({tag, " out_data"},   out_data,    '0);
        check({tag, " instr_ready"}, instr_ready, 1'b1);
    endtask

    // Drive one instruction word; returns at the falling edge after its transfer edge
    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (!instr_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            vectors++; miscompares++;
            $display("FAIL instr_ready_wait: got 0 expected 1");
            return;
        end
        instr_valid = 1'b1;
        instr_data  = d;
        @(negedge clock);
        instr_valid = 1'b0;
        instr_data  = $urandom;
    endtask

    task automatic do_load(input bit is_key, input logic [127:0] v);
        logic [31:0] w;
        send_word(is_key ? 32'h8000_0000 : 32'h8000_0001);
        for (int i = 0; i < 4; i++) begin
            w = v[127-32*i -: 32];
            send_word(w);
            if (is_key) m_key[i] = w; else m_blk[i] = w;
            check(is_key ? "load key word" : "load block word",
                  is_key ? core_key : core_block,
                  is_key ? cat4(m_key[0], m_key[1], m_key[2], m_key[3])
                         : cat4(m_blk[0], m_blk[1], m_blk[2], m_blk[3]));
        end
        check("load end ready", instr_ready, 1'b1);
        check("load end err", err, m_err);
    endtask

    // START with the core answering k cycles after core_start (k >= TMO means timeout)
    task automatic do_start(input logic mode, input int k, input logic [127:0] res);
        logic err_before;
        err_before  = m_err;
        core_result = res;
        send_word({1'b1, 26'($urandom), mode, 4'h2});
        m_mode = mode;
        check("start pulse", core_start, 1'b1);
        check("start mode", core_mode, m_mode);
        for (int i = 0; i <= 12; i++) begin
            if (i == 1) check("start pulse width", core_start, 1'b0);
            if (i <= k && i <= TMO - 1) check("run ready low", instr_ready, 1'b0);
            if (k < TMO && i == k + 1) begin
                check("done back to idle", instr_ready, 1'b1);
                check("done err", err, err_before);
            end
            if (k >= TMO && i == TMO - 1) check("pre-expiry err", err, err_before);
            if (k >= TMO && i == TMO) begin
                check("timeout err", err, 1'b1);
                check("timeout idle", instr_ready, 1'b1);
            end
            core_done = (i == k);
            @(negedge clock);
        end
        core_done = 1'b0;
        if (k < TMO) begin
            for (int j = 0; j < 4; j++) m_res[j] = res[127-32*j -: 32];
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic do_read();
        int n;
        for (int j = 0; j < 4; j++) exp_q.push_back(m_res[j]);
        send_word(32'h8000_0003 | {$urandom_range(0, 255), 8'h00});
        check("read out_valid rise", out_valid, 1'b1);
        check("read ready low", instr_ready, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL read_drain: got %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        check("read out_valid drop", out_valid, 1'b0);
        check("read back idle", instr_ready, 1'b1);
    endtask

    task automatic do_bad(input logic [31:0] w);
        send_word(w);
        m_err = 1'b1;
        check("bad err", err, 1'b1);
        check("bad key kept", core_key, cat4(m_key[0], m_key[1], m_key[2], m_key[3]));
        check("bad ready", instr_ready, 1'b1);
    endtask

    task automatic do_clear();
        send_word(32'h8000_000F);
        m_err = 1'b0;
        check("clear err", err, 1'b0);
    endtask

    // Output monitor: randomizes out_ready, compares every presented word
    always @(negedge clock) begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL out_unexpected: got %h expected no word", out_data);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Main sequence
    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        do_load(1'b1, 128'hEC0D7191_6EAF70A0_864CDFE0_DDA97CA4);
        check("key vector", core_key, 128'hEC0D7191_6EAF70A0_864CDFE0_DDA97CA4);
        do_read();                                      // zeros before any run
        do_load(1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        do_start(1'b1, 3, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        do_read();

        do_bad(32'h0000_0004);
        do_bad(32'h8000_0007);
        do_clear();

        do_start(1'b0, 10, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);  // timeout, late done
        do_read();                                      // old result kept
        do_clear();
        do_start(1'b1, TMO - 1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0); // done at expiry wins
        check("boundary err", err, 1'b0);
        do_read();

        // reset in the middle of a LOAD after two payload words
        do_bad(32'h0000_0001);
        send_word(32'h8000_0000);
        send_word(32'hFFFF_FFFF);
        send_word(32'h1234_5678);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid-load reset");
        @(negedge clock);
        reset_n = 1'b1;
        do_load(1'b0, 128'hCAFEF00D_00000001_80000000_7FFFFFFF);
        check("post reset key", core_key, '0);
        do_read();

        // random command mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0: do_load(1'b1, {$urandom, $urandom, $urandom, $urandom});
                1: do_load(1'b0, {$urandom, $urandom, $urandom, $urandom});
                2: do_start(1'($urandom), $urandom_range(0, 12), {$urandom, $urandom, $urandom, $urandom});
                3: do_read();
                4: do_bad($urandom & 32'h7FFF_FFFF);
                5: do_bad(32'h8000_0000 | 32'($urandom_range(4, 14)));
                default: do_clear();
            endcase
            check("rand err", err, m_err);
            check("rand mode", core_mode, m_mode);
            check("rand block", core_block, cat4(m_blk[0], m_blk[1], m_blk[2], m_blk[3]));
        end

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
